// File: rtl/cache_refill_arbiter_if.sv
// cache_refill_arbiter_if
//   Bundles the three sides of the refill arbiter into one interface:
//   - I-cache refill side : iIReq/iIAddr in, oIGnt/oIValid/oIData/oIDone out
//   - D-cache side        : iDReq/iDWe/iDAddr/iDWData in,
//                           oDGnt/oDValid/oDRData/oDDone out
//   - memory port         : oMReq/oMWe/oMAddr/oMWData out, iMAck/iMRData in
//   The arbiter connects through the slave modport; whatever drives the
//   requests and models memory (caches, memory controller, bench) uses master.
interface cache_refill_arbiter_if #(
    parameter int ADDR_W = 30
);
    logic              iIReq;
    logic [ADDR_W-1:0] iIAddr;
    logic              oIGnt;
    logic              oIValid;
    logic [31:0]       oIData;
    logic              oIDone;

    logic              iDReq;
    logic              iDWe;
    logic [ADDR_W-1:0] iDAddr;
    logic [31:0]       iDWData;
    logic              oDGnt;
    logic              oDValid;
    logic [31:0]       oDRData;
    logic              oDDone;

    logic              oMReq;
    logic              oMWe;
    logic [ADDR_W-1:0] oMAddr;
    logic [31:0]       oMWData;
    logic              iMAck;
    logic [31:0]       iMRData;

    modport slave (
        input  iIReq, iIAddr,
        output oIGnt, oIValid, oIData, oIDone,
        input  iDReq, iDWe, iDAddr, iDWData,
        output oDGnt, oDValid, oDRData, oDDone,
        output oMReq, oMWe, oMAddr, oMWData,
        input  iMAck, iMRData
    );

    modport master (
        output iIReq, iIAddr,
        input  oIGnt, oIValid, oIData, oIDone,
        output iDReq, iDWe, iDAddr, iDWData,
        input  oDGnt, oDValid, oDRData, oDDone,
        input  oMReq, oMWe, oMAddr, oMWData,
        output iMAck, iMRData
    );
endinterface

// File: rtl/cache_refill_arbiter.sv
// cache_refill_arbiter
//   Shares one backing-memory port between the I-cache refill path and the
//   D-cache refill/write-back path. Whole bursts of BURST_LEN words are
//   arbitrated round-robin; the granted burst is sequenced beat by beat over
//   a req/ack memory handshake, always walking the aligned block from its
//   first word.
// Ports:
//   iCLK  - clock, all state on the rising edge
//   iRST  - asynchronous active-low reset
//   bus   - cache_refill_arbiter_if.slave (I side, D side, memory port)
module cache_refill_arbiter #(
    parameter int BURST_LEN = 4,
    parameter int ADDR_W    = 30
) (
    input  logic                   iCLK,
    input  logic                   iRST,
    cache_refill_arbiter_if.slave  bus
);
    localparam int CntW  = $clog2(BURST_LEN);
    localparam int BaseW = ADDR_W - CntW;

    typedef enum logic [1:0] {IDLE, REQ, GAP, DONE} stateT;

    stateT             state, nextState;
    logic              own, nextOwn;      // 1 = D side owns the burst
    logic              last, nextLast;    // side served most recently, 1 = D
    logic [CntW-1:0]   cnt, nextCnt;
    logic [BaseW-1:0]  base, nextBase;    // block base, low bits implied zero
    logic              grantD;

    logic              nIGnt, nIValid, nIDone;
    logic              nDGnt, nDValid, nDDone;
    logic              nMReq, nMWe;
    logic [ADDR_W-1:0] nMAddr;
    logic [31:0]       nIData, nDRData;

    // Word offsets inside the block are replaced by the beat counter.
    logic              unusedAddrBits;
    assign unusedAddrBits = ^{bus.iIAddr[CntW-1:0], bus.iDAddr[CntW-1:0]};

    // State register: control state plus every registered output. Reset
    // abandons any beat in flight and makes I win the first tie.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state       <= IDLE;
            own         <= 1'b0;
            last        <= 1'b1;
            cnt         <= '0;
            base        <= '0;
            bus.oIGnt   <= 1'b0;
            bus.oIValid <= 1'b0;
            bus.oIDone  <= 1'b0;
            bus.oIData  <= '0;
            bus.oDGnt   <= 1'b0;
            bus.oDValid <= 1'b0;
            bus.oDDone  <= 1'b0;
            bus.oDRData <= '0;
            bus.oMReq   <= 1'b0;
            bus.oMWe    <= 1'b0;
            bus.oMAddr  <= '0;
        end else begin
            state       <= nextState;
            own         <= nextOwn;
            last        <= nextLast;
            cnt         <= nextCnt;
            base        <= nextBase;
            bus.oIGnt   <= nIGnt;
            bus.oIValid <= nIValid;
            bus.oIDone  <= nIDone;
            bus.oIData  <= nIData;
            bus.oDGnt   <= nDGnt;
            bus.oDValid <= nDValid;
            bus.oDDone  <= nDDone;
            bus.oDRData <= nDRData;
            bus.oMReq   <= nMReq;
            bus.oMWe    <= nMWe;
            bus.oMAddr  <= nMAddr;
        end
    end

    // Next-state logic. On a tie the side opposite the last one served wins;
    // requests arriving mid-burst simply wait for the next IDLE cycle.
    always_comb begin
        nextState = state;
        nextOwn   = own;
        nextLast  = last;
        nextCnt   = cnt;
        nextBase  = base;
        grantD    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.iIReq || bus.iDReq) begin
                    grantD    = bus.iDReq && (!bus.iIReq || !last);
                    nextOwn   = grantD;
                    nextLast  = grantD;
                    nextCnt   = '0;
                    nextBase  = grantD ? bus.iDAddr[ADDR_W-1:CntW]
                                       : bus.iIAddr[ADDR_W-1:CntW];
                    nextState = REQ;
                end
            end
            REQ: begin
                if (bus.iMAck) begin
                    nextState = GAP;
                end
            end
            GAP: begin
                if (cnt == CntW'(BURST_LEN - 1)) begin
                    nextState = DONE;
                end else begin
                    nextCnt   = cnt + 1'b1;
                    nextState = REQ;
                end
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Output logic: computes the values the output registers take on the
    // next edge, so every handshake output lines up with the state it
    // belongs to. Read data is captured only on an acked beat.
    always_comb begin
        nMReq   = (nextState == REQ);
        nMWe    = nMReq && nextOwn && bus.iDWe;
        nMAddr  = nMReq ? {nextBase, nextCnt} : '0;
        nIGnt   = (nextState != IDLE) && !nextOwn;
        nDGnt   = (nextState != IDLE) && nextOwn;
        nIValid = (nextState == GAP) && !nextOwn;
        nDValid = (nextState == GAP) && nextOwn;
        nIDone  = (nextState == DONE) && !nextOwn;
        nDDone  = (nextState == DONE) && nextOwn;
        nIData  = bus.oIData;
        nDRData = bus.oDRData;
        if (state == REQ && bus.iMAck) begin
            if (own) begin
                nDRData = bus.iMRData;
            end else begin
                nIData = bus.iMRData;
            end
        end
    end

    // Write data passes straight through so the requester can present the
    // next word during GAP without an extra register stage.
    assign bus.oMWData = (state == REQ && own && bus.iDWe) ? bus.iDWData : '0;

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// tb_cache_refill_arbiter
//   Scoreboard bench for cache_refill_arbiter: tests push expected memory
//   beats, returned words and burst completions into queues; an independent
//   monitor pops and compares them whenever the DUT presents a beat, a valid
//   or a done pulse. The memory model acks after a programmable stall and
//   returns address + 0x1000 as read data.
module tb_cache_refill_arbiter;
    localparam int ADDR_W = 30;

    logic clk = 1'b0;
    logic rstN;

    cache_refill_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    cache_refill_arbiter #(.BURST_LEN(4), .ADDR_W(ADDR_W)) dut (
        .iCLK (clk),
        .iRST (rstN),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
    } beatT;

    typedef struct packed {
        logic        chk;
        logic [31:0] data;
    } dataT;

    beatT        memIQ[$];
    beatT        memDQ[$];
    logic [31:0] iQ[$];
    dataT        dQ[$];
    bit          doneQ[$];

    int assertCount = 0;
    int failCount   = 0;
    int cycleCnt    = 0;
    int stallCycles = 0;
    int waitCnt     = 0;

    // Memory model: with no stall the ack is tied high, otherwise it is
    // raised once the request has waited stallCycles cycles.
    always @(posedge clk) cycleCnt <= cycleCnt + 1;
    always @(posedge clk) waitCnt <= (bus.oMReq && !bus.iMAck) ? waitCnt + 1 : 0;
    assign bus.iMAck   = (stallCycles == 0) ? 1'b1 : (bus.oMReq && (waitCnt >= stallCycles));
    assign bus.iMRData = {2'b00, bus.oMAddr} + 32'h1000;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkBeat(input string name, input beatT b);
        checkOutput({name, "Addr"}, bus.oMAddr, b.addr);
        checkOutput({name, "We"}, bus.oMWe, b.we);
        checkOutput({name, "WData"}, bus.oMWData, b.wdata);
    endtask

    function automatic void pushRead(input bit side, input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] a;
        for (int k = 0; k < 4; k++) begin
            a = {addr[ADDR_W-1:2], 2'(k)};
            if (side) begin
                memDQ.push_back('{we: 1'b0, addr: a, wdata: 32'h0});
                dQ.push_back('{chk: 1'b1, data: {2'b00, a} + 32'h1000});
            end else begin
                memIQ.push_back('{we: 1'b0, addr: a, wdata: 32'h0});
                iQ.push_back({2'b00, a} + 32'h1000);
            end
        end
        doneQ.push_back(side);
    endfunction

    // Monitor: compares every accepted beat, returned word and done pulse
    // against the queues, and checks beat spacing and stall stability.
    initial begin
        logic              accept;
        logic              prevAccept;
        logic              prevStall;
        logic [ADDR_W-1:0] prevAddr;
        beatT              b;
        dataT              d;
        logic [31:0]       w;
        bit                s;
        prevAccept = 1'b0;
        prevStall  = 1'b0;
        prevAddr   = '0;
        forever begin
            @(negedge clk);
            if (!rstN) begin
                prevAccept = 1'b0;
                prevStall  = 1'b0;
            end else begin
                accept = bus.oMReq && bus.iMAck;
                if (bus.oIGnt || bus.oDGnt)
                    checkOutput("grantExclusive", bus.oIGnt & bus.oDGnt, 0);
                if (prevStall) begin
                    checkOutput("stallReqHeld", bus.oMReq, 1);
                    checkOutput("stallAddrHeld", bus.oMAddr, prevAddr);
                end
                if (prevAccept) begin
                    checkOutput("reqGapAfterAck", bus.oMReq, 0);
                    checkOutput("validAfterAck", bus.oIValid | bus.oDValid, 1);
                end
                if (accept) begin
                    checkOutput("beatHasGrant", bus.oIGnt | bus.oDGnt, 1);
                    if (bus.oIGnt) begin
                        checkOutput("iBeatExpected", memIQ.size() > 0, 1);
                        if (memIQ.size() > 0) begin
                            b = memIQ.pop_front();
                            checkBeat("iBeat", b);
                        end
                    end else if (bus.oDGnt) begin
                        checkOutput("dBeatExpected", memDQ.size() > 0, 1);
                        if (memDQ.size() > 0) begin
                            b = memDQ.pop_front();
                            checkBeat("dBeat", b);
                        end
                    end
                end
                if (bus.oIValid) begin
                    checkOutput("iValidTiming", prevAccept, 1);
                    checkOutput("iValidExpected", iQ.size() > 0, 1);
                    if (iQ.size() > 0) begin
                        w = iQ.pop_front();
                        checkOutput("iData", bus.oIData, w);
                    end
                end
                if (bus.oDValid) begin
                    checkOutput("dValidTiming", prevAccept, 1);
                    checkOutput("dValidExpected", dQ.size() > 0, 1);
                    if (dQ.size() > 0) begin
                        d = dQ.pop_front();
                        if (d.chk) checkOutput("dData", bus.oDRData, d.data);
                    end
                end
                if (bus.oIDone || bus.oDDone) begin
                    checkOutput("doneExpected", doneQ.size() > 0, 1);
                    if (doneQ.size() > 0) begin
                        s = doneQ.pop_front();
                        checkOutput("doneSide", bus.oDDone, s);
                    end
                end
                prevAccept = accept;
                prevStall  = bus.oMReq && !bus.iMAck;
                prevAddr   = bus.oMAddr;
            end
        end
    end

    // Requester for one burst: raises the request, advances write data
    // after each D valid, optionally drops the request early, and releases
    // it on the edge after done. Must be entered just after a rising edge.
    task automatic applyStimulus(input bit side, input bit we, input logic [ADDR_W-1:0] addr,
                                 input logic [31:0] wbase, input int dropAfter,
                                 output int startCycle, output int doneCycle);
        int budget;
        int valids;
        bit seen;
        bit started;
        budget = 0; valids = 0; seen = 1'b0; started = 1'b0;
        startCycle = -1; doneCycle = -1;
        if (side) begin
            bus.iDReq = 1'b1; bus.iDWe = we; bus.iDAddr = addr; bus.iDWData = wbase;
        end else begin
            bus.iIReq = 1'b1; bus.iIAddr = addr;
        end
        while (!seen && budget < 300) begin
            @(negedge clk);
            budget++;
            if (!started && (side ? bus.oDGnt : bus.oIGnt)) begin
                started = 1'b1;
                startCycle = cycleCnt;
            end
            if (side ? bus.oDDone : bus.oIDone) begin
                seen = 1'b1;
                doneCycle = cycleCnt;
            end else if (side ? bus.oDValid : bus.oIValid) begin
                valids++;
                @(posedge clk);
                #1;
                if (side && we) bus.iDWData = bus.iDWData + 32'd1;
                if (dropAfter > 0 && valids == dropAfter) begin
                    if (side) bus.iDReq = 1'b0;
                    else bus.iIReq = 1'b0;
                end
            end
        end
        checkOutput(side ? "dDoneSeen" : "iDoneSeen", seen, 1);
        @(posedge clk);
        #1;
        if (side) bus.iDReq = 1'b0;
        else bus.iIReq = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "IGnt"}, bus.oIGnt, 0);
        checkOutput({tag, "IValid"}, bus.oIValid, 0);
        checkOutput({tag, "IDone"}, bus.oIDone, 0);
        checkOutput({tag, "IData"}, bus.oIData, 0);
        checkOutput({tag, "DGnt"}, bus.oDGnt, 0);
        checkOutput({tag, "DValid"}, bus.oDValid, 0);
        checkOutput({tag, "DDone"}, bus.oDDone, 0);
        checkOutput({tag, "DRData"}, bus.oDRData, 0);
        checkOutput({tag, "MReq"}, bus.oMReq, 0);
        checkOutput({tag, "MWe"}, bus.oMWe, 0);
        checkOutput({tag, "MAddr"}, bus.oMAddr, 0);
        checkOutput({tag, "MWData"}, bus.oMWData, 0);
    endtask

    initial begin
        int t0, iStart, iDone, dStart, dDone;
        logic [ADDR_W-1:0] expAddr[4];
        rstN = 1'b0;
        bus.iIReq = 1'b0; bus.iIAddr = '0;
        bus.iDReq = 1'b0; bus.iDWe = 1'b0; bus.iDAddr = '0; bus.iDWData = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkAllZero("reset");
        rstN = 1'b1;

        // Reset asserted while a stalled beat is being requested.
        $display("[TB] reset during stalled request");
        stallCycles = 6;
        @(posedge clk); #1;
        bus.iIReq = 1'b1; bus.iIAddr = 30'h50;
        @(posedge clk);
        @(negedge clk);
        checkOutput("preResetReq", bus.oMReq, 1);
        checkOutput("preResetAddr", bus.oMAddr, 30'h50);
        #2 rstN = 1'b0;
        #1 checkAllZero("asyncReset");
        bus.iIReq = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        stallCycles = 0;

        // Tie after reset: I first (done in cycle 10), D one IDLE cycle later.
        $display("[TB] simultaneous requests after reset");
        pushRead(1'b0, 30'h40);
        pushRead(1'b1, 30'h83);
        @(posedge clk); #1;
        t0 = cycleCnt;
        fork
            applyStimulus(1'b0, 1'b0, 30'h40, 32'h0, 0, iStart, iDone);
            applyStimulus(1'b1, 1'b0, 30'h83, 32'h0, 0, dStart, dDone);
        join
        checkOutput("tieIStart", iStart - t0, 1);
        checkOutput("tieIDoneCycle", iDone - t0 + 1, 10);
        checkOutput("tieDAfterIdle", dStart - iDone, 2);

        // Tie again: last served was D, so I goes first again.
        $display("[TB] repeated tie alternates");
        pushRead(1'b0, 30'h10);
        pushRead(1'b1, 30'h14);
        @(posedge clk); #1;
        fork
            applyStimulus(1'b0, 1'b0, 30'h10, 32'h0, 0, iStart, iDone);
            applyStimulus(1'b1, 1'b0, 30'h14, 32'h0, 0, dStart, dDone);
        join
        checkOutput("tie2Order", dDone > iDone, 1);

        // I read burst from an unaligned address, ack tied high.
        $display("[TB] I read burst 0x105");
        expAddr = '{30'h104, 30'h105, 30'h106, 30'h107};
        for (int k = 0; k < 4; k++) begin
            memIQ.push_back('{we: 1'b0, addr: expAddr[k], wdata: 32'h0});
        end
        iQ.push_back(32'h1104); iQ.push_back(32'h1105);
        iQ.push_back(32'h1106); iQ.push_back(32'h1107);
        doneQ.push_back(1'b0);
        @(posedge clk); #1;
        t0 = cycleCnt;
        applyStimulus(1'b0, 1'b0, 30'h105, 32'h0, 0, iStart, iDone);
        checkOutput("iBurstStart", iStart - t0, 1);
        checkOutput("iBurstDoneCycle", iDone - t0 + 1, 10);

        // Tie after an I burst: D wins this time.
        $display("[TB] tie after I burst");
        pushRead(1'b1, 30'h200);
        pushRead(1'b0, 30'h208);
        @(posedge clk); #1;
        fork
            applyStimulus(1'b0, 1'b0, 30'h208, 32'h0, 0, iStart, iDone);
            applyStimulus(1'b1, 1'b0, 30'h200, 32'h0, 0, dStart, dDone);
        join
        checkOutput("tie3Order", iDone > dDone, 1);

        // D write burst, data advanced by the requester on each valid.
        $display("[TB] D write burst 0x20");
        for (int k = 0; k < 4; k++) begin
            memDQ.push_back('{we: 1'b1, addr: 30'h20 + 30'(k), wdata: 32'hA0 + 32'(k)});
            dQ.push_back('{chk: 1'b0, data: 32'h0});
        end
        doneQ.push_back(1'b1);
        @(posedge clk); #1;
        applyStimulus(1'b1, 1'b1, 30'h20, 32'hA0, 0, dStart, dDone);

        // Memory stalls three cycles per beat.
        $display("[TB] D read with memory stalls");
        stallCycles = 3;
        pushRead(1'b1, 30'h31);
        @(posedge clk); #1;
        t0 = cycleCnt;
        applyStimulus(1'b1, 1'b0, 30'h31, 32'h0, 0, dStart, dDone);
        checkOutput("stallDoneCycle", dDone - t0 + 1, 1 + 4 * 5 + 1);
        stallCycles = 0;

        // D request arrives during an I burst whose request drops early.
        $display("[TB] D waits for I burst with dropped request");
        pushRead(1'b0, 30'h300);
        pushRead(1'b1, 30'h400);
        @(posedge clk); #1;
        fork
            applyStimulus(1'b0, 1'b0, 30'h300, 32'h0, 1, iStart, iDone);
            begin
                repeat (3) @(posedge clk);
                #1;
                applyStimulus(1'b1, 1'b0, 30'h400, 32'h0, 0, dStart, dDone);
            end
        join
        checkOutput("dropDAfterIdle", dStart - iDone, 2);

        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("memIQEmpty", memIQ.size(), 0);
        checkOutput("memDQEmpty", memDQ.size(), 0);
        checkOutput("iQEmpty", iQ.size(), 0);
        checkOutput("dQEmpty", dQ.size(), 0);
        checkOutput("doneQEmpty", doneQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
